// File: rtl/ultrasonic_pkg.sv
// Shared timing constants and FSM encodings for the HC-SR04 echo emulator.
// Defaults assume a 50 MHz clock.
package ultrasonic_pkg;

  localparam int unsigned CYC_PER_US       = 50;
  localparam int unsigned DEF_TRIG_MIN_CYC = 10 * CYC_PER_US;
  localparam int unsigned DEF_BURST_CYC    = 200 * CYC_PER_US;
  localparam int unsigned DEF_CYC_PER_CM   = 58 * CYC_PER_US;
  localparam int unsigned DEF_MAX_CM       = 400;
  localparam int unsigned DEF_TIMEOUT_CYC  = 38000 * CYC_PER_US;
  localparam int unsigned DEF_HOLDOFF_CYC  = 10000 * CYC_PER_US;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_TRIG  = 3'd1;
  localparam logic [2:0] S_BURST = 3'd2;
  localparam logic [2:0] S_ECHO  = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  // Out-of-range or zero distance reports the no-target timeout width.
  function automatic logic [31:0] echo_target(
    input logic [15:0] cm,
    input int unsigned cyc_per_cm,
    input int unsigned max_cm,
    input int unsigned timeout_cyc
  );
    logic [31:0] cm32;
    logic [31:0] prod;
    cm32 = {16'd0, cm};
    prod = cm32 * cyc_per_cm;
    if (cm32 != 32'd0 && cm32 <= max_cm)
      return prod;
    return timeout_cyc;
  endfunction

endpackage

// File: rtl/ultrasonic_echo_emulator_trig_qualifier.sv
// Trigger synchronizer, arming, edge detect and width qualification.
// Emits registered rise, ok and short pulses.
module trig_qualifier
  import ultrasonic_pkg::*;
#(
  parameter int unsigned TRIG_MIN_CYC = DEF_TRIG_MIN_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic i_trig,
  output logic o_rise,
  output logic o_ok,
  output logic o_short
);

  logic        r_s1;
  logic        r_s2;
  logic        r_s3;
  logic [1:0]  r_prime;
  logic        r_armed;
  logic        r_inpulse;
  logic [31:0] r_wcnt;
  logic        r_rise;
  logic        r_ok;
  logic        r_short;
  logic        w_rise;
  logic        w_fall;
  logic        w_long;

  assign w_rise = r_armed & r_s2 & ~r_s3;
  assign w_fall = ~r_s2 & r_s3;
  assign w_long = (r_wcnt >= TRIG_MIN_CYC);

  // r_prime keeps reset-value zeros in the sync chain from arming us.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_s3      <= 1'b0;
      r_prime   <= 2'b00;
      r_armed   <= 1'b0;
      r_inpulse <= 1'b0;
      r_wcnt    <= 32'd0;
      r_rise    <= 1'b0;
      r_ok      <= 1'b0;
      r_short   <= 1'b0;
    end else begin
      r_s1    <= i_trig;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_prime <= {r_prime[0], 1'b1};
      r_armed <= r_armed | (r_prime[1] & ~r_s2);
      r_rise  <= w_rise;
      r_ok    <= w_fall & r_inpulse & w_long;
      r_short <= w_fall & r_inpulse & ~w_long;
      if (w_rise) begin
        r_inpulse <= 1'b1;
        r_wcnt    <= 32'd1;
      end else if (w_fall) begin
        r_inpulse <= 1'b0;
      end else if (r_s2 && r_inpulse && !w_long) begin
        r_wcnt <= r_wcnt + 32'd1;
      end
    end
  end

  assign o_rise  = r_rise;
  assign o_ok    = r_ok;
  assign o_short = r_short;

endmodule

// File: rtl/ultrasonic_echo_emulator.sv
// HC-SR04 responder: trigger -> burst delay -> echo sized by dist_cm.
// ULTRASONIC_EMU_REJECT_CNT_EN adds a saturating reject_cnt output.
module ultrasonic_echo_emulator
  import ultrasonic_pkg::*;
#(
  parameter int unsigned TRIG_MIN_CYC = DEF_TRIG_MIN_CYC,
  parameter int unsigned BURST_CYC    = DEF_BURST_CYC,
  parameter int unsigned CYC_PER_CM   = DEF_CYC_PER_CM,
  parameter int unsigned MAX_CM       = DEF_MAX_CM,
  parameter int unsigned TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
  parameter int unsigned HOLDOFF_CYC  = DEF_HOLDOFF_CYC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trigger,
  input  logic [15:0] dist_cm,
  output logic        echo,
  output logic        busy,
  output logic        short_trig
`ifdef ULTRASONIC_EMU_REJECT_CNT_EN
  ,
  output logic [7:0]  reject_cnt
`endif
);

  logic [2:0]  r_state;
  logic [15:0] r_snap;
  logic [31:0] r_cnt;
  logic        r_echo;
  logic        r_short;
  logic        w_rise;
  logic        w_ok;
  logic        w_short;
  logic        w_busy;
  logic [31:0] w_target;

  trig_qualifier #(
    .TRIG_MIN_CYC(TRIG_MIN_CYC)
  ) u_qual (
    .clk    (clk),
    .reset  (reset),
    .i_trig (trigger),
    .o_rise (w_rise),
    .o_ok   (w_ok),
    .o_short(w_short)
  );

  assign w_target = echo_target(r_snap, CYC_PER_CM, MAX_CM, TIMEOUT_CYC);
  assign w_busy   = (r_state == S_BURST) || (r_state == S_ECHO)
                 || (r_state == S_HOLD);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_snap  <= 16'd0;
      r_cnt   <= 32'd0;
      r_echo  <= 1'b0;
      r_short <= 1'b0;
    end else begin
      r_short <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_rise)
            r_state <= S_TRIG;
        end
        S_TRIG: begin
          if (w_ok) begin
            r_state <= S_BURST;
            r_snap  <= dist_cm;
            r_cnt   <= 32'd0;
          end else if (w_short) begin
            r_state <= S_IDLE;
            r_short <= 1'b1;
          end
        end
        S_BURST: begin
          if (r_cnt == BURST_CYC - 1) begin
            r_state <= S_ECHO;
            r_echo  <= 1'b1;
            r_cnt   <= w_target;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        // r_cnt holds remaining high cycles including the current one.
        S_ECHO: begin
          if (r_cnt == 32'd1) begin
            r_state <= S_HOLD;
            r_echo  <= 1'b0;
            r_cnt   <= 32'd0;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        S_HOLD: begin
          if (r_cnt == HOLDOFF_CYC - 1) begin
            r_state <= S_IDLE;
            r_cnt   <= 32'd0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ULTRASONIC_EMU_REJECT_CNT_EN
  logic [7:0] r_rej;
  logic       w_rej;

  assign w_rej = ((r_state == S_TRIG) && !w_ok && w_short)
              || (w_rise && w_busy);

  always_ff @(posedge clk) begin
    if (reset)
      r_rej <= 8'd0;
    else if (w_rej && r_rej != 8'hFF)
      r_rej <= r_rej + 8'd1;
  end

  assign reject_cnt = r_rej;
`endif

  assign echo       = r_echo;
  assign busy       = w_busy;
  assign short_trig = r_short;

endmodule
